// File: rtl/hpc3_rand_source.sv
// Mask-randomness supplier for the 4-share HPC3 multiplier: a 128-bit LFSR
// advanced 96 steps per transfer, seeded over a 32-bit stream with warm-up and periodic reseed.
module hpc3_rand_source #(
    parameter int unsigned WARMUP_CYC      = 4,
    parameter int unsigned RESEED_INTERVAL = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed_data,
    input  logic        seed_valid,
    output logic        seed_ready,
    input  logic        rnd_ready,
    output logic        rnd_valid,
    output logic [7:0]  r01,
    output logic [7:0]  r02,
    output logic [7:0]  r03,
    output logic [7:0]  r12,
    output logic [7:0]  r13,
    output logic [7:0]  r23,
    output logic [7:0]  p01,
    output logic [7:0]  p02,
    output logic [7:0]  p03,
    output logic [7:0]  p12,
    output logic [7:0]  p13,
    output logic [7:0]  p23,
    output logic        reseed_req,
    output logic [15:0] xfer_cnt
);

    localparam int unsigned STATE_W   = 128;
    localparam int unsigned MASK_W    = 96;
    localparam int unsigned SHADOW_W  = 96;
    localparam int unsigned ADV_STEPS = 96;
    localparam int unsigned XFER_W    = 16;
    localparam int unsigned WARM_W    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);
    localparam logic [31:0] RESEED_LAST =
        32'((RESEED_INTERVAL > 0) ? RESEED_INTERVAL - 1 : 0);
    localparam bit WARM_EN   = (WARMUP_CYC != 0);
    localparam bit RESEED_EN = (RESEED_INTERVAL != 0);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [STATE_W-1:0]   s_q, s_d;
    logic [SHADOW_W-1:0]  shadow_q, shadow_d;
    logic [1:0]           beat_q, beat_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [XFER_W-1:0]    xfer_q, xfer_d;
    logic                 rnd_valid_q;
    logic                 in_seed_q;
    logic [MASK_W-1:0]    mask_q;

    // 96 Fibonacci steps unrolled into one combinational advance.
    function automatic logic [STATE_W-1:0] adv(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] t;
        t = x;
        for (int unsigned i = 0; i < ADV_STEPS; i++) begin
            t = {t[STATE_W-2:0], t[127] ^ t[28] ^ t[26] ^ t[1]};
        end
        return t;
    endfunction

    // An all-zero state would lock the LFSR; substitute 1.
    function automatic logic [STATE_W-1:0] zguard(input logic [STATE_W-1:0] x);
        return (x == '0) ? STATE_W'(1) : x;
    endfunction

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        shadow_d = shadow_q;
        beat_d   = beat_q;
        warm_d   = warm_q;
        xfer_d   = xfer_q;
        unique case (state_q)
            ST_SEED: begin
                if (seed_valid) begin
                    beat_d = beat_q + 2'd1;
                    unique case (beat_q)
                        2'd0: shadow_d[31:0]  = seed_data;
                        2'd1: shadow_d[63:32] = seed_data;
                        2'd2: shadow_d[95:64] = seed_data;
                        default: begin
                            // Final beat is mixed in directly rather than via the shadow.
                            s_d     = zguard(s_q ^ {seed_data, shadow_q});
                            state_d = WARM_EN ? ST_WARMUP : ST_RUN;
                        end
                    endcase
                end
            end
            ST_WARMUP: begin
                s_d = adv(s_q);
                if (warm_q == WARM_LAST) begin
                    warm_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (rnd_ready) begin
                    s_d = adv(s_q);
                    if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
                    if (RESEED_EN && (32'(xfer_q) == RESEED_LAST)) begin
                        state_d = ST_SEED;
                        xfer_d  = '0;
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = ST_SEED;
        endcase
    end

    // Status and masks are registered from next-state values so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEED;
            s_q         <= '0;
            shadow_q    <= '0;
            beat_q      <= '0;
            warm_q      <= '0;
            xfer_q      <= '0;
            rnd_valid_q <= 1'b0;
            in_seed_q   <= 1'b1;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            shadow_q    <= shadow_d;
            beat_q      <= beat_d;
            warm_q      <= warm_d;
            xfer_q      <= xfer_d;
            rnd_valid_q <= (state_d == ST_RUN);
            in_seed_q   <= (state_d == ST_SEED);
            mask_q      <= (state_d == ST_RUN) ? s_d[MASK_W-1:0] : '0;
        end
    end

    assign rnd_valid  = rnd_valid_q;
    assign seed_ready = in_seed_q;
    assign reseed_req = in_seed_q;
    assign xfer_cnt   = xfer_q;

    assign r01 = mask_q[7:0];
    assign r02 = mask_q[15:8];
    assign r03 = mask_q[23:16];
    assign r12 = mask_q[31:24];
    assign r13 = mask_q[39:32];
    assign r23 = mask_q[47:40];
    assign p01 = mask_q[55:48];
    assign p02 = mask_q[63:56];
    assign p03 = mask_q[71:64];
    assign p12 = mask_q[79:72];
    assign p13 = mask_q[87:80];
    assign p23 = mask_q[95:88];

endmodule

// File: tb/tb_hpc3_rand_source.sv
// Directed bench for hpc3_rand_source: two instances (no warm-up / short reseed,
// and default-style warm-up / no reseed) checked against an LFSR reference.
module tb_hpc3_rand_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic        a_rst_n, a_seed_valid, a_seed_ready, a_rnd_ready, a_rnd_valid, a_reseed_req;
    logic [31:0] a_seed_data;
    logic [15:0] a_xfer_cnt;
    logic [7:0]  a_r01, a_r02, a_r03, a_r12, a_r13, a_r23;
    logic [7:0]  a_p01, a_p02, a_p03, a_p12, a_p13, a_p23;
    logic [95:0] a_masks;

    logic        b_rst_n, b_seed_valid, b_seed_ready, b_rnd_ready, b_rnd_valid, b_reseed_req;
    logic [31:0] b_seed_data;
    logic [15:0] b_xfer_cnt;
    logic [7:0]  b_r01, b_r02, b_r03, b_r12, b_r13, b_r23;
    logic [7:0]  b_p01, b_p02, b_p03, b_p12, b_p13, b_p23;
    logic [95:0] b_masks;

    logic [127:0] ms;
    logic [31:0]  beats_a [4] = '{32'h1, 32'h0, 32'h0, 32'h0};
    logic [31:0]  beats_b [4] = '{32'h00000001, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
    logic [31:0]  beats_c [4] = '{32'hA5A5_0F0F, 32'h0000_0000, 32'h1357_9BDF, 32'h8000_0001};
    logic         rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0]  xfer_pat [4] = '{16'd1, 16'd1, 16'd1, 16'd2};

    assign a_masks = {a_p23, a_p13, a_p12, a_p03, a_p02, a_p01, a_r23, a_r13, a_r12, a_r03, a_r02, a_r01};
    assign b_masks = {b_p23, b_p13, b_p12, b_p03, b_p02, b_p01, b_r23, b_r13, b_r12, b_r03, b_r02, b_r01};

    hpc3_rand_source #(.WARMUP_CYC(0), .RESEED_INTERVAL(3)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .seed_data(a_seed_data), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
        .rnd_ready(a_rnd_ready), .rnd_valid(a_rnd_valid),
        .r01(a_r01), .r02(a_r02), .r03(a_r03), .r12(a_r12), .r13(a_r13), .r23(a_r23),
        .p01(a_p01), .p02(a_p02), .p03(a_p03), .p12(a_p12), .p13(a_p13), .p23(a_p23),
        .reseed_req(a_reseed_req), .xfer_cnt(a_xfer_cnt)
    );

    hpc3_rand_source #(.WARMUP_CYC(4), .RESEED_INTERVAL(0)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .seed_data(b_seed_data), .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
        .rnd_ready(b_rnd_ready), .rnd_valid(b_rnd_valid),
        .r01(b_r01), .r02(b_r02), .r03(b_r03), .r12(b_r12), .r13(b_r13), .r23(b_r23),
        .p01(b_p01), .p02(b_p02), .p03(b_p03), .p12(b_p12), .p13(b_p13), .p23(b_p23),
        .reseed_req(b_reseed_req), .xfer_cnt(b_xfer_cnt)
    );

    function automatic logic [127:0] m_adv(input logic [127:0] x);
        for (int i = 0; i < 96; i++) x = {x[126:0], x[127] ^ x[28] ^ x[26] ^ x[1]};
        return x;
    endfunction

    function automatic logic [127:0] m_z(input logic [127:0] x);
        return (x == 128'h0) ? 128'h1 : x;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_seed_valid = 1'b0; a_seed_data = '0; a_rnd_ready = 1'b0;
        b_rst_n = 1'b0; b_seed_valid = 1'b0; b_seed_data = '0; b_rnd_ready = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_valid", a_rnd_valid, 1'b0);
        check("rst_seed_ready", a_seed_ready, 1'b1);
        check("rst_reseed_req", a_reseed_req, 1'b1);
        check("rst_masks", a_masks, 96'h0);
        check("rst_xfer", a_xfer_cnt, 16'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // All-zero seed hits the zero guard
        for (int k = 0; k < 4; k++) begin
            check("a0_seed_ready", a_seed_ready, 1'b1);
            a_seed_data = 32'h0; a_seed_valid = 1'b1;
            tick();
        end
        a_seed_valid = 1'b0;
        ms = 128'h1;
        check("a0_valid", a_rnd_valid, 1'b1);
        check("a0_masks", a_masks, 96'h1);
        check("a0_reseed_req", a_reseed_req, 1'b0);
        check("a0_seed_ready_run", a_seed_ready, 1'b0);

        a_rnd_ready = 1'b1;
        for (int h = 1; h <= 2; h++) begin
            tick();
            ms = m_adv(ms);
            check("a0_hs_masks", a_masks, ms[95:0]);
            check("a0_hs_xfer", a_xfer_cnt, 16'(h));
        end
        tick();
        ms = m_adv(ms);
        check("a_reseed_valid", a_rnd_valid, 1'b0);
        check("a_reseed_req", a_reseed_req, 1'b1);
        check("a_reseed_seed_ready", a_seed_ready, 1'b1);
        check("a_reseed_xfer", a_xfer_cnt, 16'h0);
        check("a_reseed_masks", a_masks, 96'h0);

        // Reseed mixes into the advanced state; rnd_ready stays high and is ignored in SEED
        for (int k = 0; k < 4; k++) begin
            a_seed_data = beats_a[k]; a_seed_valid = 1'b1;
            tick();
        end
        a_seed_valid = 1'b0;
        ms = m_z(ms ^ 128'h1);
        check("a1_valid", a_rnd_valid, 1'b1);
        check("a1_masks", a_masks, ms[95:0]);
        check("a1_xfer", a_xfer_cnt, 16'h0);
        tick();
        ms = m_adv(ms);
        check("a1_hs_masks", a_masks, ms[95:0]);
        check("a1_hs_xfer", a_xfer_cnt, 16'h1);
        a_rnd_ready = 1'b0;

        // Warm-up of four advances; seed_valid during warm-up is ignored
        for (int k = 0; k < 4; k++) begin
            b_seed_data = beats_b[k]; b_seed_valid = 1'b1;
            tick();
        end
        ms = {beats_b[3], beats_b[2], beats_b[1], beats_b[0]};
        b_seed_data = 32'hFFFF_FFFF;
        for (int w = 0; w < 4; w++) begin
            check("b_warm_valid", b_rnd_valid, 1'b0);
            check("b_warm_seed_ready", b_seed_ready, 1'b0);
            tick();
        end
        b_seed_valid = 1'b0;
        for (int w = 0; w < 4; w++) ms = m_adv(ms);
        check("b_first_valid", b_rnd_valid, 1'b1);
        check("b_first_masks", b_masks, ms[95:0]);

        // Back-pressure holds the set; seed_valid in RUN is ignored
        b_seed_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_rnd_ready = rdy_pat[i];
            tick();
            if (rdy_pat[i]) ms = m_adv(ms);
            check("b_bp_masks", b_masks, ms[95:0]);
            check("b_bp_xfer", b_xfer_cnt, xfer_pat[i]);
            check("b_bp_seed_ready", b_seed_ready, 1'b0);
        end
        b_rnd_ready = 1'b0; b_seed_valid = 1'b0;

        // Asynchronous reset from RUN takes effect without a clock edge
        #2;
        b_rst_n = 1'b0;
        #1;
        check("b_async_valid", b_rnd_valid, 1'b0);
        check("b_async_seed_ready", b_seed_ready, 1'b1);
        check("b_async_xfer", b_xfer_cnt, 16'h0);
        check("b_async_masks", b_masks, 96'h0);
        tick();
        b_rst_n = 1'b1;
        tick();

        // Two partial beats, then reset: a full four beats are required afterwards
        for (int k = 0; k < 2; k++) begin
            b_seed_data = 32'h5555_0000 + 32'(k); b_seed_valid = 1'b1;
            tick();
        end
        b_seed_valid = 1'b0;
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            b_seed_data = beats_c[k]; b_seed_valid = 1'b1;
            tick();
        end
        check("b_partial_seed_ready", b_seed_ready, 1'b1);
        check("b_partial_reseed_req", b_reseed_req, 1'b1);
        b_seed_data = beats_c[3];
        tick();
        b_seed_valid = 1'b0;
        check("b_c_warm_seed_ready", b_seed_ready, 1'b0);
        repeat (4) tick();
        ms = {beats_c[3], beats_c[2], beats_c[1], beats_c[0]};
        for (int w = 0; w < 4; w++) ms = m_adv(ms);
        check("b_c_valid", b_rnd_valid, 1'b1);
        check("b_c_masks", b_masks, ms[95:0]);

        // Long continuous stream with reseeding disabled
        b_rnd_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            ms = m_adv(ms);
            check("b_stream_masks", b_masks, ms[95:0]);
            check("b_stream_reseed_req", b_reseed_req, 1'b0);
        end
        b_rnd_ready = 1'b0;
        check("b_stream_xfer", b_xfer_cnt, 16'd2000);
        check("b_stream_valid", b_rnd_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
